// File: rtl/spi_peripheral_pkg.sv
// Shared SPI target types: FSM state encoding and camera opcode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPCODE  = 2'd1,
        OPERAND = 2'd2
    } spi_state_t;

    // Opcodes shared with the register file decode.
    localparam logic [7:0] START_CAPTURE = 8'h20;
    localparam logic [7:0] STOP_CAPTURE  = 8'h21;
    localparam logic [7:0] SET_EXPOSURE  = 8'h22;
    localparam logic [7:0] SET_GAIN      = 8'h23;
    localparam logic [7:0] READ_STATUS   = 8'h24;
    localparam logic [7:0] READ_REG      = 8'h25;
    localparam logic [7:0] WRITE_REG     = 8'h26;
    localparam logic [7:0] SET_WINDOW    = 8'h30;
    localparam logic [7:0] GAMMA_BYPASS  = 8'h32;

endpackage

// File: rtl/spi_peripheral_if.sv
// Pin-side and register-file-side signal bundle of the SPI target.
// Latency: n/a (wiring only).
// Backpressure: none; the SPI host sets the pace, the register file answers combinationally.
interface spi_peripheral_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   spi_select_in;
    logic                   spi_clock_in;
    logic                   spi_data_in;
    logic                   spi_data_out;
    logic [7:0]             opcode_out;
    logic                   opcode_valid_out;
    logic [7:0]             operand_out;
    logic                   operand_valid_out;
    logic                   operand_read_out;
    logic [COUNT_WIDTH-1:0] rd_operand_count_out;
    logic [7:0]             response_in;

    // Host pins plus register file: drives the inputs, observes the strobes.
    modport master (
        output spi_select_in, spi_clock_in, spi_data_in, response_in,
        input  spi_data_out, opcode_out, opcode_valid_out, operand_out,
               operand_valid_out, operand_read_out, rd_operand_count_out
    );

    // The SPI target itself.
    modport slave (
        input  spi_select_in, spi_clock_in, spi_data_in, response_in,
        output spi_data_out, opcode_out, opcode_valid_out, operand_out,
               operand_valid_out, operand_read_out, rd_operand_count_out
    );
endinterface

// File: rtl/spi_peripheral_pin_sync.sv
// Brings one asynchronous SPI pin into clock_in and keeps the previous synced value.
// Latency: SYNC_STAGES cycles to sync_out, one more to prev_out.
// Backpressure: none.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n_in,
    input  logic pin_in,
    output logic sync_out,
    output logic prev_out
);
    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q, prev_d;

    // Shift the pin into the chain; remember the last synced value for edge detection.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], pin_in};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    // Synchroniser and previous-value flops.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_out = chain_q[SYNC_STAGES-1];
    assign prev_out = prev_q;
endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: byte 0 is the opcode, later bytes are operands; CIPO returns response_in.
// Latency: SCK pin edge to strobes is SYNC_STAGES+2 clock_in cycles.
// Backpressure: none; the register file must accept one operand per byte time.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 32
) (
    input  logic            clock_in,
    input  logic            reset_n_in,
    spi_peripheral_if.slave bus
);
    logic cs_sync, cs_prev, sck_sync, sck_prev, mosi_sync, mosi_prev;
    logic sck_rise, sck_fall, cs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .pin_in(bus.spi_select_in),
        .sync_out(cs_sync), .prev_out(cs_prev));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .pin_in(bus.spi_clock_in),
        .sync_out(sck_sync), .prev_out(sck_prev));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .pin_in(bus.spi_data_in),
        .sync_out(mosi_sync), .prev_out(mosi_prev));

    spi_state_t             state_q, state_d;
    logic                   armed_q, armed_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   done_op_q, done_op_d;
    logic                   done_arg_q, done_arg_d;
    logic [7:0]             opcode_q, opcode_d;
    logic                   opcode_vld_q, opcode_vld_d;
    logic [7:0]             operand_q, operand_d;
    logic                   operand_pulse_q, operand_pulse_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    assign sck_rise = sck_sync & ~sck_prev & ~cs_sync;
    assign sck_fall = ~sck_sync & sck_prev & ~cs_sync;
    assign cs_fall  = cs_prev & ~cs_sync;

    // Framing, shifting and output updates; CS high overrides everything, including a pending byte.
    always_comb begin
        state_d         = state_q;
        armed_d         = armed_q;
        bit_cnt_d       = bit_cnt_q;
        rx_d            = rx_q;
        tx_d            = tx_q;
        done_op_d       = 1'b0;
        done_arg_d      = 1'b0;
        opcode_d        = opcode_q;
        opcode_vld_d    = opcode_vld_q;
        operand_d       = operand_q;
        operand_pulse_d = 1'b0;
        count_d         = count_q;

        if (cs_sync) begin
            armed_d      = 1'b1;
            state_d      = IDLE;
            bit_cnt_d    = 3'd0;
            rx_d         = 8'd0;
            tx_d         = 8'd0;
            count_d      = '0;
            opcode_vld_d = 1'b0;
        end else begin
            if (state_q == IDLE) begin
                // Only a CS fall seen after CS was high starts a frame, so a reset mid-frame stays quiet.
                if (cs_fall && armed_q) begin
                    state_d = OPCODE;
                end
            end else begin
                if (sck_rise) begin
                    // COPI is taken one cycle behind SCK to give hold margin if the host moves it early.
                    rx_d      = {rx_q[6:0], mosi_prev};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == OPCODE) begin
                            done_op_d = 1'b1;
                            state_d   = OPERAND;
                        end else begin
                            done_arg_d = 1'b1;
                        end
                    end
                end
                if (sck_fall) begin
                    // At a byte boundary after the opcode, pick up the register file answer.
                    if (state_q == OPERAND && bit_cnt_q == 3'd0) begin
                        tx_d = bus.response_in;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            if (done_op_q) begin
                opcode_d     = rx_q;
                opcode_vld_d = 1'b1;
            end
            if (done_arg_q) begin
                operand_d       = rx_q;
                operand_pulse_d = 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // All state on the asynchronous reset.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q         <= IDLE;
            armed_q         <= 1'b0;
            bit_cnt_q       <= 3'd0;
            rx_q            <= 8'd0;
            tx_q            <= 8'd0;
            done_op_q       <= 1'b0;
            done_arg_q      <= 1'b0;
            opcode_q        <= 8'd0;
            opcode_vld_q    <= 1'b0;
            operand_q       <= 8'd0;
            operand_pulse_q <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            armed_q         <= armed_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_q            <= rx_d;
            tx_q            <= tx_d;
            done_op_q       <= done_op_d;
            done_arg_q      <= done_arg_d;
            opcode_q        <= opcode_d;
            opcode_vld_q    <= opcode_vld_d;
            operand_q       <= operand_d;
            operand_pulse_q <= operand_pulse_d;
            count_q         <= count_d;
        end
    end

    assign bus.spi_data_out         = tx_q[7];
    assign bus.opcode_out           = opcode_q;
    assign bus.opcode_valid_out     = opcode_vld_q;
    assign bus.operand_out          = operand_q;
    assign bus.operand_valid_out    = operand_pulse_q;
    assign bus.operand_read_out     = operand_pulse_q;
    assign bus.rd_operand_count_out = count_q;
endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
module tb_spi_peripheral;
    import spi_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 4;   // SCK half period in clock_in cycles (SCK = clock_in/8)

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_peripheral_if #(.COUNT_WIDTH(32)) bus ();
    spi_peripheral_if #(.COUNT_WIDTH(2))  bus_n ();

    spi_peripheral #(.SYNC_STAGES(SYNC), .COUNT_WIDTH(32)) dut (
        .clock_in(clk), .reset_n_in(rst_n), .bus(bus.slave));
    // Narrow-count copy on the same pins to see saturation.
    spi_peripheral #(.SYNC_STAGES(SYNC), .COUNT_WIDTH(2)) dut_n (
        .clock_in(clk), .reset_n_in(rst_n), .bus(bus_n.slave));

    logic [7:0] resp_base;
    assign bus.response_in     = resp_base + bus.rd_operand_count_out[7:0];
    assign bus_n.spi_select_in = bus.spi_select_in;
    assign bus_n.spi_clock_in  = bus.spi_clock_in;
    assign bus_n.spi_data_in   = bus.spi_data_in;
    assign bus_n.response_in   = 8'h00;

    int tests = 0;
    int fails = 0;

    // Strobe recorder.
    logic [7:0]  mon_ops[$];
    logic [31:0] mon_cnt[$];
    int          rd_pulses = 0;
    int          n_pulses = 0;
    always @(negedge clk) begin
        if (bus.operand_valid_out) begin
            mon_ops.push_back(bus.operand_out);
            mon_cnt.push_back(bus.rd_operand_count_out);
        end
        if (bus.operand_read_out) rd_pulses++;
        if (bus_n.operand_valid_out) n_pulses++;
    end

    logic [7:0] frame_ops[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        mon_ops.delete();
        mon_cnt.delete();
        rd_pulses = 0;
        n_pulses  = 0;
    endtask

    // Mode 0 host: set COPI, wait, sample CIPO, raise SCK, wait, lower SCK.
    task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] miso_b);
        miso_b = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_data_in = b[7-i];
            tick(HALF);
            miso_b = {miso_b[6:0], bus.spi_data_out};
            bus.spi_clock_in = 1'b1;
            tick(HALF);
            bus.spi_clock_in = 1'b0;
        end
    endtask

    // One frame: opcode, the bytes in frame_ops, then tail_bits of a partial byte, then CS high.
    task automatic run_frame(input string tag, input logic [7:0] op, input int tail_bits);
        logic [7:0] m;
        int         n;
        n = frame_ops.size();
        clear_mon();
        bus.spi_select_in = 1'b0;
        tick(4);
        xfer(op, 8, m);
        chk({tag, "_miso_opcode"}, m, 8'h00);
        chk({tag, "_opcode"}, bus.opcode_out, op);
        chk({tag, "_opvld"}, bus.opcode_valid_out, 1'b1);
        for (int j = 0; j < n; j++) begin
            xfer(frame_ops[j], 8, m);
            chk({tag, "_miso"}, m, 8'(resp_base + 8'(j)));
        end
        if (tail_bits > 0) xfer(8'($urandom), tail_bits, m);
        tick(1);
        chk({tag, "_count"}, bus.rd_operand_count_out, n);
        chk({tag, "_count_sat"}, bus_n.rd_operand_count_out, (n > 3) ? 3 : n);
        chk({tag, "_opvld_end"}, bus.opcode_valid_out, 1'b1);
        bus.spi_select_in = 1'b1;
        tick(SYNC + 2);
        chk({tag, "_opvld_cs"}, bus.opcode_valid_out, 1'b0);
        chk({tag, "_count_cs"}, bus.rd_operand_count_out, 0);
        chk({tag, "_count_sat_cs"}, bus_n.rd_operand_count_out, 0);
        chk({tag, "_miso_cs"}, bus.spi_data_out, 1'b0);
        chk({tag, "_opcode_hold"}, bus.opcode_out, op);
        chk({tag, "_pulses"}, mon_ops.size(), n);
        chk({tag, "_rd_pulses"}, rd_pulses, n);
        chk({tag, "_n_pulses"}, n_pulses, n);
        for (int j = 0; j < n && j < mon_ops.size(); j++) begin
            chk({tag, "_operand"}, mon_ops[j], frame_ops[j]);
            chk({tag, "_cnt_at_pulse"}, mon_cnt[j], j + 1);
        end
        if (n > 0) chk({tag, "_operand_hold"}, bus.operand_out, frame_ops[n-1]);
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] op;
        int         nops;
        int         tail;

        bus.spi_select_in = 1'b1;
        bus.spi_clock_in  = 1'b0;
        bus.spi_data_in   = 1'b0;
        resp_base         = 8'hA0;
        rst_n             = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(6);

        // Reset state
        chk("rst_opcode", bus.opcode_out, 0);
        chk("rst_opvld", bus.opcode_valid_out, 0);
        chk("rst_operand", bus.operand_out, 0);
        chk("rst_opndvld", bus.operand_valid_out, 0);
        chk("rst_opndrd", bus.operand_read_out, 0);
        chk("rst_count", bus.rd_operand_count_out, 0);
        chk("rst_miso", bus.spi_data_out, 0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));

        // Opcode 0x26, one operand 0x03
        frame_ops = '{8'h03};
        run_frame("wr", 8'h26, 0);
        chk("wr_operand_keep", bus.operand_out, 8'h03);

        // Opcode 0x25, three operands, CIPO returns A0, A1, A2
        resp_base = 8'hA0;
        frame_ops = '{8'h11, 8'h22, 8'h33};
        run_frame("rd", 8'h25, 0);

        // CS released after 5 bits of the second operand
        frame_ops = '{8'h5A};
        run_frame("abort", 8'h25, 5);

        // Reset pulsed mid-byte with CS low and SCK running: nothing decodes
        bus.spi_select_in = 1'b0;
        tick(4);
        xfer(8'hFF, 3, m);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_mon();
        xfer(8'hAA, 8, m);
        xfer(8'h55, 8, m);
        tick(2);
        chk("midrst_opvld", bus.opcode_valid_out, 0);
        chk("midrst_opcode", bus.opcode_out, 0);
        chk("midrst_count", bus.rd_operand_count_out, 0);
        chk("midrst_pulses", mon_ops.size(), 0);
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        bus.spi_select_in = 1'b1;
        tick(SYNC + 2);
        frame_ops = '{8'h00};
        run_frame("after_rst", 8'h30, 0);

        // Back-to-back random frames with CS high for 4 cycles between them
        for (int f = 0; f < 8; f++) begin
            op        = 8'h20 + 8'($urandom_range(0, 18));
            nops      = $urandom_range(0, 5);
            tail      = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            resp_base = 8'($urandom);
            frame_ops.delete();
            for (int k = 0; k < nops; k++) frame_ops.push_back(8'($urandom));
            run_frame("rand", op, tail);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
